// File: rtl/alu_mdu_seq_if.sv
// Request/response bundle for the iterative multiply/divide unit.
interface alu_mdu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             busy;

  modport master (
    output in_valid, op, A, B, flush, out_ready,
    input  in_ready, out_valid, C, busy
  );

  modport slave (
    input  in_valid, op, A, B, flush, out_ready,
    output in_ready, out_valid, C, busy
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// Iterative RV-style multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign fixed at the end.
module alu_mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  alu_mdu_seq_if.slave bus
);
  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [2*W-1:0] acc_q, acc_d;   // mul: {hi, multiplier}; div: {rem, quotient}
  logic [W-1:0]   opnd_q, opnd_d; // mul: multiplicand; div: divisor
  logic [W-1:0]   c_q, c_d;
  logic           neg_q, neg_d;   // product / quotient sign
  logic           nrem_q, nrem_d; // remainder sign (follows A)

  // Request decode: operand signedness, magnitudes and the 1-cycle special cases
  logic         is_div, sa, sb, div_zero, div_ovf;
  logic [W-1:0] ma, mb;
  always_comb begin
    is_div   = bus.op[2];
    sa       = bus.A[W-1] & (is_div ? ~bus.op[0] : (bus.op[1:0] != 2'b11));
    sb       = bus.B[W-1] & (is_div ? ~bus.op[0] : ~bus.op[1]);
    ma       = sa ? -bus.A : bus.A;
    mb       = sb ? -bus.B : bus.B;
    div_zero = is_div && (bus.B == '0);
    div_ovf  = is_div && !bus.op[0] && (bus.A == {1'b1, {(W-1){1'b0}}}) && (bus.B == '1);
  end

  // One iteration of the datapath plus the final sign fix-up and result select
  logic [W:0]     sum, sh;
  logic           ge;
  logic [2*W-1:0] step, prod;
  logic [W-1:0]   quo, rem, res;
  always_comb begin
    sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    sh  = acc_q[2*W-1:W-1];
    ge  = (sh >= {1'b0, opnd_q});
    if (op_q[2]) begin
      step = ge ? {W'(sh - {1'b0, opnd_q}), acc_q[W-2:0], 1'b1}
                : {acc_q[2*W-2:0], 1'b0};
    end else begin
      step = {sum, acc_q[W-1:1]};
    end
    prod = neg_q  ? -step : step;
    quo  = neg_q  ? -step[W-1:0] : step[W-1:0];
    rem  = nrem_q ? -step[2*W-1:W] : step[2*W-1:W];
    if (op_q[2])              res = op_q[1] ? rem : quo;
    else if (op_q == 3'b000)  res = prod[W-1:0];
    else                      res = prod[2*W-1:W];
  end

  // Next-state logic: flush beats accept and handoff
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    c_d     = c_q;
    neg_d   = neg_q;
    nrem_d  = nrem_q;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_d   = bus.op;
            neg_d  = sa ^ sb;
            nrem_d = sa;
            cnt_d  = '0;
            if (div_zero) begin
              c_d     = bus.op[1] ? bus.A : '1;
              state_d = DONE;
            end else if (div_ovf) begin
              c_d     = bus.op[1] ? '0 : bus.A;
              state_d = DONE;
            end else begin
              acc_d   = is_div ? {{W{1'b0}}, ma} : {{W{1'b0}}, mb};
              opnd_d  = is_div ? mb : ma;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            c_d     = res;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      c_q     <= '0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      c_q     <= c_d;
      neg_q   <= neg_d;
      nrem_q  <= nrem_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.C         = c_q;
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq at WIDTH=32.
module tb_alu_mdu_seq;
  localparam int unsigned W = 32;
  localparam int LAT_ITER = 32;
  // Special cases enter DONE at the accept edge, so the result is already
  // on the bus in the cycle right after it: zero further edges.
  localparam int LAT_SPEC = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mdu_seq_if #(.WIDTH(W)) bus();
  alu_mdu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_c;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  // Reference using native wide arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // One transaction: issue, measure latency, optionally stall the result, hand off
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_c, input int exp_lat,
                        input int hold);
    int n;
    logic [31:0] e;
    int el;
    @(negedge clk);
    check({tag, ".rdy"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.A         = a;
    bus.B         = b;
    bus.out_ready = 1'b0;
    exp_q.push_back(exp_c);
    lat_q.push_back(exp_lat);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    bus.op       = 3'($urandom);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check({tag, ".lat"}, 64'(n), 64'(el));
    check({tag, ".C"}, bus.C, e);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = $urandom;
      bus.B        = $urandom;
      @(posedge clk);
      #1;
      check({tag, ".holdC"}, bus.C, e);
      check({tag, ".holdV"}, {bus.out_valid, bus.in_ready}, 2'b10);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, ".idle"}, {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    last_c = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          rlat, n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.A         = '0;
    bus.B         = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("reset", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    check("reset.C", bus.C, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Multiply family
    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_ITER, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_ITER, 0);
    run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT_ITER, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_ITER, 0);
    // Divide family
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_ITER, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_ITER, 0);
    run_op("divu",   3'd5, 32'd100,       32'd7, 32'd14,        LAT_ITER, 0);
    run_op("remu",   3'd7, 32'd100,       32'd7, 32'd2,         LAT_ITER, 0);
    // Divide-by-zero and signed overflow short paths
    run_op("div0",   3'd4, 32'd100,       32'd0,         32'hFFFF_FFFF, LAT_SPEC, 0);
    run_op("remu0",  3'd7, 32'd100,       32'd0,         32'd100,       LAT_SPEC, 0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         LAT_SPEC, 0);
    // Back-pressure: result held for 10 cycles with in_valid pulsing
    run_op("stall",  3'd5, 32'd1000,      32'd9,         32'd111,       LAT_ITER, 10);
    run_op("after",  3'd0, 32'd6,         32'd7,         32'd42,        LAT_ITER, 0);

    // Flush at iteration 10 with a competing request
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 3'd4;
    bus.A        = 32'd1000;
    bus.B        = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush.busy", bus.busy, 1);
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 3'd0;
    bus.A        = 32'd5;
    bus.B        = 32'd5;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush.idle", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) n++;
    end
    check("flush.nov", 64'(n), 64'd0);
    check("flush.C", bus.C, last_c);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 3'd0;
    bus.A        = 32'd9;
    bus.B        = 32'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    check("arst.C", bus.C, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op("mul3x5", 3'd0, 32'd3, 32'd5, 32'd15, LAT_ITER, 0);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      rlat = (rop[2] && (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)))
             ? LAT_SPEC : LAT_ITER;
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), rlat, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_mdu_seq.md
ALU_MDU_SEQ -- requirements
Module: alu_mdu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; legal values are 8..64, even.
REQ-002 The block SHALL have port clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  request valid.
REQ-005 The block SHALL have port in_ready  output  1  request accept; in_ready = (state==IDLE).
REQ-006 The block SHALL have port op  input  3  operation select: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-007 The block SHALL have port A  input  WIDTH  operand 1 (rs1).
REQ-008 The block SHALL have port B  input  WIDTH  operand 2 (rs2).
REQ-009 The block SHALL have port flush  input  1  synchronous abort.
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_ready  input  1  result consumed.
REQ-012 The block SHALL have port C  output  WIDTH  registered result.
REQ-013 The block SHALL have port busy  output  1  busy = (state!=IDLE).

Function
REQ-014 The block SHALL implement states IDLE, CALC and DONE.
REQ-015 The block SHALL accept a request on a rising edge where in_valid && in_ready, and SHALL capture op, A and B at that edge; operands SHALL NOT be sampled at any other time.
REQ-016 On accept, the block SHALL enter CALC with iteration counter 0, except in the special cases of REQ-020/021, which SHALL enter DONE directly.
REQ-017 In CALC, the block SHALL perform exactly one iteration per cycle: shift-add for multiplication, restoring shift-subtract for division. After iteration WIDTH-1 it SHALL enter DONE, so out_valid is first high exactly WIDTH cycles after the accept edge.
REQ-018 Multiplication SHALL use operand magnitudes with a final sign fix-up and produce a 2*WIDTH product: mul returns the low half; mulh (signed×signed), mulhsu (signed A × unsigned B) and mulhu (unsigned×unsigned) return the high half.
REQ-019 Signed division SHALL truncate toward zero. The remainder SHALL take the sign of A; quotient = (A - rem)/B.
REQ-020 For div/divu/rem/remu with B==0, the result SHALL be: quotient all ones; remainder = A. Latency SHALL be 1 cycle.
REQ-021 For signed div/rem with A = most-negative value and B = -1, the result SHALL be: quotient = A; remainder = 0. Latency SHALL be 1 cycle.
REQ-022 In DONE, out_valid SHALL be 1 and C SHALL hold the result stable until a rising edge with out_ready=1, which returns the block to IDLE.
REQ-023 A new request SHALL NOT be accepted in the same cycle as result handoff; minimum issue interval = latency + 1 cycle.
REQ-024 While in IDLE, out_valid SHALL be 0 and C SHALL hold its last value.
REQ-025 flush=1 at a rising edge SHALL force IDLE and clear out_valid from any state, discarding any in-progress result. flush SHALL take priority over accept and handoff, and in_valid in the same cycle SHALL NOT be accepted.
REQ-026 An op value not listed in REQ-006 SHALL NOT exist, because op is fully decoded.
REQ-027 All arithmetic SHALL be exact for every WIDTH; no intermediate value may be truncated before the final selection.

Reset
REQ-028 Asserting rst SHALL immediately set state=IDLE, out_valid=0, C=0, busy=0 and iteration counter=0, including mid-CALC; in_ready SHALL read 1 while rst is asserted.
REQ-029 After rst deasserts, the first request SHALL be acceptable on the first rising edge.

Verification (WIDTH=32)
REQ-030 The bench SHALL apply mul A=7, B=0xFFFFFFFD -> C=0xFFFFFFEB, out_valid rising 32 cycles after accept; mulhu A=B=0xFFFFFFFF -> C=0xFFFFFFFE; mulh same operands -> C=0x00000000; mulhsu A=0xFFFFFFFF, B=2 -> C=0xFFFFFFFF.
REQ-031 The bench SHALL apply div A=0xFFFFFFF9 (-7), B=2 -> C=0xFFFFFFFD; rem same -> C=0xFFFFFFFF; divu A=100, B=7 -> C=14; remu -> C=2; each completing in 32 cycles.
REQ-032 The bench SHALL apply div A=100, B=0 -> C=0xFFFFFFFF with out_valid 1 cycle after accept; remu A=100, B=0 -> C=100; div A=0x80000000, B=0xFFFFFFFF -> C=0x80000000; rem same -> C=0 in 1 cycle.
REQ-033 The bench SHALL hold out_ready=0 for 10 cycles after out_valid -> C stable, in_ready=0, in_valid ignored; on out_ready=1 -> IDLE next cycle, then accept the next request on the following edge.
REQ-034 The bench SHALL assert flush at CALC iteration 10 with in_valid=1 -> IDLE, out_valid stays 0, no accept that edge. It SHALL also assert rst asynchronously mid-CALC -> out_valid=0 and C=0 immediately, and a fresh mul 3×5 after release -> C=15.
